pwm_regfile_shadow: RTL and testbench

- Parametrised multi-channel PWM register file with preload/active (shadow) register pairs.
- Sits between the host bus and the PWM core.
- Timing values written by the host land in preload registers. They are copied to the active outputs only at a core period boundary, or on a forced update, so the core never sees a half-updated configuration.
- Adds a sticky W1C status register, an interrupt output, address-error detection and a registered read path.

---
 rtl/pwm_regs_pkg.sv | 30 +++
 rtl/pwm_regfile_shadow_if.sv | 11 +
 rtl/pwm_shadow_reg.sv | 21 ++
 rtl/pwm_regfile_shadow.sv | 99 +++++++++
 tb/tb_pwm_regfile_shadow.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/pwm_regs_pkg.sv
// pwm_regs_pkg: register map constants, GCTRL/STATUS bit indices and channel address decode for pwm_regfile_shadow
package pwm_regs_pkg;
  localparam int unsigned GCTRL = 0;
  localparam int unsigned PERIOD = 1;
  localparam int unsigned PRESC = 2;
  localparam int unsigned DEADTIME = 3;
  localparam int unsigned STATUS = 4;
  localparam int unsigned IRQ_EN = 5;
  localparam int unsigned CH_BASE = 16;
  localparam int unsigned CH_STRIDE = 2;
  localparam int G_EN = 0;
  localparam int G_MODE = 1;
  localparam int G_DTEN = 2;
  localparam int G_PRE = 3;
  localparam int G_FORCE = 4;
  localparam int S_UPD = 0;
  localparam int S_AERR = 1;
  typedef struct packed {
    logic vld;
    logic dly;
    logic [4:0] ch;
  } ch_info_t;
  function automatic ch_info_t ch_decode(input int unsigned a, input int unsigned nch);
    ch_info_t o;
    o.vld = (a >= CH_BASE) && (a < CH_BASE + CH_STRIDE * nch);
    o.dly = a[0];
    o.ch = 5'((a - CH_BASE) / CH_STRIDE);
    return o;
  endfunction
endpackage

// File: rtl/pwm_regfile_shadow_if.sv
// pwm_regfile_shadow_if: host register bus (wr_en/rd_en/addr/wr_data in, rd_data/rd_valid out) with master/slave modports
interface pwm_regfile_shadow_if #(parameter int WIDTH = 16, parameter int ADDR_W = 6);
  logic wr_en;
  logic rd_en;
  logic [ADDR_W-1:0] addr;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] rd_data;
  logic rd_valid;
  modport master(output wr_en, rd_en, addr, wr_data, input rd_data, rd_valid);
  modport slave(input wr_en, rd_en, addr, wr_data, output rd_data, rd_valid);
endinterface

// File: rtl/pwm_shadow_reg.sv
// pwm_shadow_reg: preload/active pair; wr writes pre (and act when transparent), load copies the pre-write pre into act
module pwm_shadow_reg #(parameter int WIDTH = 16) (
  input  logic clk,
  input  logic rst,
  input  logic wr,
  input  logic transparent,
  input  logic load,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] pre,
  output logic [WIDTH-1:0] act
);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pre <= '0;
      act <= '0;
    end else begin
      if (wr) pre <= wdata;
      if (load) act <= pre;
      else if (wr && transparent) act <= wdata;
    end
endmodule

// File: rtl/pwm_regfile_shadow.sv
// pwm_regfile_shadow: PWM register file (clk, rst, bus slave, update_evt in; en/mode/deadtime_en, period/prescaler_div/deadtime_val, duty/delay, irq out)
module pwm_regfile_shadow
  import pwm_regs_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NCH = 4,
  parameter int ADDR_W = 6
) (
  input  logic clk,
  input  logic rst,
  pwm_regfile_shadow_if.slave bus,
  input  logic update_evt,
  output logic en,
  output logic mode,
  output logic deadtime_en,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] prescaler_div,
  output logic [WIDTH-1:0] deadtime_val,
  output logic [NCH*WIDTH-1:0] duty,
  output logic [NCH*WIDTH-1:0] delay,
  output logic irq
);
  localparam int NS = 3 + 2 * NCH;
  localparam int SW = $clog2(NS);
  int unsigned a;
  ch_info_t ci;
  logic sh_hit, mapped, gctrl_wr, sh_wr, force_upd, upd, pre_en, pending;
  logic [SW-1:0] sh_idx;
  logic [1:0] status, irq_en, st_set, st_clr;
  logic [WIDTH-1:0] rd_mux;
  logic [WIDTH-1:0] pre [NS];
  logic [WIDTH-1:0] act [NS];
  // shadow slots: 0..2 period/presc/deadtime, then duty/delay interleaved per channel
  always_comb begin
    a = 32'(bus.addr);
    ci = ch_decode(a, NCH);
    sh_hit = (a >= PERIOD && a <= DEADTIME) || ci.vld;
    mapped = a <= IRQ_EN || ci.vld;
    sh_idx = ci.vld ? SW'(32'd3 + 32'(ci.ch) * 2 + 32'(ci.dly)) : SW'(a - 1);
    gctrl_wr = bus.wr_en && a == GCTRL;
    sh_wr = bus.wr_en && sh_hit;
    force_upd = gctrl_wr && bus.wr_data[G_FORCE];
    upd = (update_evt && pending) || force_upd;
    st_set = '0;
    st_set[S_UPD] = upd;
    st_set[S_AERR] = (bus.wr_en || bus.rd_en) && !mapped;
    st_clr = (bus.wr_en && a == STATUS) ? bus.wr_data[1:0] : 2'b00;
    rd_mux = a == GCTRL ? WIDTH'({pre_en, deadtime_en, mode, en}) :
             a == STATUS ? WIDTH'(status) :
             a == IRQ_EN ? WIDTH'(irq_en) :
             sh_hit ? pre[sh_idx] : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      en <= 1'b0;
      mode <= 1'b0;
      deadtime_en <= 1'b0;
      pre_en <= 1'b0;
      pending <= 1'b0;
      status <= '0;
      irq_en <= '0;
      irq <= 1'b0;
      bus.rd_valid <= 1'b0;
      bus.rd_data <= '0;
    end else begin
      if (gctrl_wr) begin
        en <= bus.wr_data[G_EN];
        mode <= bus.wr_data[G_MODE];
        deadtime_en <= bus.wr_data[G_DTEN];
        pre_en <= bus.wr_data[G_PRE];
      end
      if (bus.wr_en && a == IRQ_EN) irq_en <= bus.wr_data[1:0];
      // a shadow write coinciding with an update re-arms pending for the next boundary
      pending <= (pending && !upd) || (sh_wr && pre_en);
      status <= (status & ~st_clr) | st_set;
      irq <= |(status & irq_en);
      bus.rd_valid <= bus.rd_en;
      if (bus.rd_en) bus.rd_data <= rd_mux;
    end
  for (genvar k = 0; k < NS; k++) begin : g_sh
    pwm_shadow_reg #(.WIDTH(WIDTH)) u_reg (
      .clk(clk),
      .rst(rst),
      .wr(sh_wr && sh_idx == SW'(k)),
      .transparent(!pre_en),
      .load(upd),
      .wdata(bus.wr_data),
      .pre(pre[k]),
      .act(act[k])
    );
  end
  assign period = act[0];
  assign prescaler_div = act[1];
  assign deadtime_val = act[2];
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign duty[c*WIDTH +: WIDTH] = act[3+2*c];
    assign delay[c*WIDTH +: WIDTH] = act[4+2*c];
  end
endmodule

// File: tb/tb_pwm_regfile_shadow.sv
// tb_pwm_regfile_shadow: scoreboard bench; stimulus queues expected reads/probes, a negedge monitor pops and compares
module tb_pwm_regfile_shadow;
  localparam int W = 16;
  localparam int NCH = 4;
  localparam int AW = 6;
  localparam int P_PERIOD = 0, P_DUTY = 1, P_DELAY = 2, P_IRQ = 3, P_EN = 4, P_RDATA = 5, P_RVALID = 6;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic update_evt = 1'b0;
  logic en, mode, deadtime_en, irq;
  logic [W-1:0] period, prescaler_div, deadtime_val;
  logic [NCH*W-1:0] duty, delay;
  typedef struct {
    int sel;
    int ch;
    logic [31:0] exp;
    string name;
  } probe_t;
  probe_t pq[$];
  logic [W-1:0] rq[$];
  int errors = 0;
  int checks = 0;
  pwm_regfile_shadow_if #(.WIDTH(W), .ADDR_W(AW)) bus();
  pwm_regfile_shadow #(.WIDTH(W), .NCH(NCH), .ADDR_W(AW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .update_evt(update_evt),
    .en(en),
    .mode(mode),
    .deadtime_en(deadtime_en),
    .period(period),
    .prescaler_div(prescaler_div),
    .deadtime_val(deadtime_val),
    .duty(duty),
    .delay(delay),
    .irq(irq)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] pv(input int sel, input int ch);
    case (sel)
      P_PERIOD: return 32'(period);
      P_DUTY: return 32'(duty[ch*W +: W]);
      P_DELAY: return 32'(delay[ch*W +: W]);
      P_IRQ: return 32'(irq);
      P_EN: return 32'(en);
      P_RDATA: return 32'(bus.rd_data);
      default: return 32'(bus.rd_valid);
    endcase
  endfunction
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic pr(input int sel, input int ch, input logic [31:0] exp, input string name);
    probe_t p;
    p.sel = sel;
    p.ch = ch;
    p.exp = exp;
    p.name = name;
    pq.push_back(p);
  endtask
  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d, input logic evt, input logic rd, input logic [W-1:0] rexp);
    bus.wr_en = 1'b1;
    bus.addr = a;
    bus.wr_data = d;
    update_evt = evt;
    bus.rd_en = rd;
    if (rd) rq.push_back(rexp);
    cyc();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    update_evt = 1'b0;
  endtask
  task automatic w(input logic [AW-1:0] a, input logic [W-1:0] d);
    wr(a, d, 1'b0, 1'b0, '0);
  endtask
  task automatic rd(input logic [AW-1:0] a, input logic [W-1:0] exp);
    bus.rd_en = 1'b1;
    bus.addr = a;
    rq.push_back(exp);
    cyc();
    bus.rd_en = 1'b0;
  endtask
  task automatic evt();
    update_evt = 1'b1;
    cyc();
    update_evt = 1'b0;
  endtask
  always @(negedge clk) begin
    probe_t p;
    logic [W-1:0] e;
    if (bus.rd_valid) begin
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: rd_valid=1 rd_data=%h, required no read response", bus.rd_data);
      end else begin
        e = rq.pop_front();
        if (bus.rd_data !== e) begin
          errors++;
          $display("FAIL read: rd_data=%h required %h", bus.rd_data, e);
        end
      end
    end
    while (pq.size() > 0) begin
      p = pq.pop_front();
      checks++;
      if (pv(p.sel, p.ch) !== p.exp) begin
        errors++;
        $display("FAIL %s: got %h required %h", p.name, pv(p.sel, p.ch), p.exp);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.addr = '0;
    bus.wr_data = '0;
    cyc();
    cyc();
    pr(P_PERIOD, 0, 0, "rst_period");
    pr(P_DUTY, 0, 0, "rst_duty0");
    pr(P_IRQ, 0, 0, "rst_irq");
    pr(P_EN, 0, 0, "rst_en");
    pr(P_RDATA, 0, 0, "rst_rd_data");
    pr(P_RVALID, 0, 0, "rst_rd_valid");
    cyc();
    rst = 1'b0;
    cyc();
    w(6'h01, 16'h03E8);
    pr(P_PERIOD, 0, 32'h03E8, "transparent_period");
    rd(6'h01, 16'h03E8);
    w(6'h00, 16'h0008);
    w(6'h14, 16'h0100);
    pr(P_DUTY, 2, 0, "duty2_held");
    rd(6'h14, 16'h0100);
    w(6'h05, 16'h0001);
    evt();
    pr(P_DUTY, 2, 32'h0100, "duty2_updated");
    pr(P_IRQ, 0, 0, "irq_not_yet");
    rd(6'h04, 16'h0001);
    pr(P_IRQ, 0, 1, "irq_set");
    w(6'h04, 16'h0001);
    rd(6'h04, 16'h0000);
    pr(P_IRQ, 0, 0, "irq_cleared");
    w(6'h16, 16'h0077);
    wr(6'h10, 16'h0050, 1'b1, 1'b0, '0);
    pr(P_DUTY, 0, 0, "duty0_prewrite");
    pr(P_DUTY, 3, 32'h0077, "duty3_updated");
    evt();
    pr(P_DUTY, 0, 32'h0050, "duty0_next_update");
    w(6'h13, 16'h0020);
    pr(P_DELAY, 1, 0, "delay1_held");
    w(6'h00, 16'h0018);
    pr(P_DELAY, 1, 32'h0020, "delay1_forced");
    rd(6'h00, 16'h0008);
    w(6'h04, 16'h0003);
    rd(6'h04, 16'h0000);
    w(6'h3F, 16'hFFFF);
    pr(P_PERIOD, 0, 32'h03E8, "unmapped_period");
    pr(P_DUTY, 0, 32'h0050, "unmapped_duty0");
    pr(P_DUTY, 3, 32'h0077, "unmapped_duty3");
    rd(6'h04, 16'h0002);
    w(6'h04, 16'h0002);
    rd(6'h04, 16'h0000);
    rd(6'h06, 16'h0000);
    rd(6'h04, 16'h0002);
    w(6'h04, 16'h0002);
    w(6'h12, 16'h0011);
    wr(6'h04, 16'h0001, 1'b1, 1'b0, '0);
    pr(P_DUTY, 1, 32'h0011, "duty1_updated");
    rd(6'h04, 16'h0001);
    wr(6'h01, 16'h1234, 1'b0, 1'b1, 16'h03E8);
    rd(6'h01, 16'h1234);
    pr(P_PERIOD, 0, 32'h03E8, "period_pending");
    w(6'h01, 16'h5555);
    rst = 1'b1;
    pr(P_PERIOD, 0, 0, "midrst_period");
    pr(P_DUTY, 1, 0, "midrst_duty1");
    pr(P_DELAY, 1, 0, "midrst_delay1");
    pr(P_IRQ, 0, 0, "midrst_irq");
    pr(P_RDATA, 0, 0, "midrst_rd_data");
    pr(P_RVALID, 0, 0, "midrst_rd_valid");
    cyc();
    rst = 1'b0;
    cyc();
    evt();
    pr(P_PERIOD, 0, 0, "postrst_no_update");
    rd(6'h04, 16'h0000);
    rd(6'h01, 16'h0000);
    cyc();
    cyc();
    checks++;
    if (rq.size() != 0) begin
      errors++;
      $display("FAIL rd_missing: %0d reads outstanding, required 0", rq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
